ser_word_collector: RTL

Downstream consumer of the serial receiver's `SerOut`/`SerOutValid` stream. Collects contiguous valid bits into WIDTH-bit words, MSB first, and buffers completed words in a small fall-through FIFO for a parallel reader. It flags overflow and dropped partial words, and optionally drives a seven-segment display with the current FIFO occupancy.

---
 rtl/ser_word_collector.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ser_word_collector.sv
// ser_word_collector: assembles contiguous SerOutValid-qualified bits into
// WIDTH-bit words (MSB first) and buffers them in a DEPTH-entry fall-through
// FIFO. Reports dropped words (sticky overflow) and discarded partial words
// (one-cycle frag_err).
// Optional feature macro: SER_WORD_COLLECTOR_SSD_EN -- when defined, SSD shows
// the FIFO occupancy as a registered hex glyph; otherwise SSD is tied to zero.
// DEPTH must be a power of two and at least 2 (at most 8 with the display).
module ser_word_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SerOutValid,
    input  logic             SerOut,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    output logic             fifo_full,
    output logic             overflow,
    output logic             frag_err,
    output logic [6:0]       SSD
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] push_word;
    logic             push;
    logic             frag_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             full, pop, accept, drop;

    // Assembler next-state: shift on every valid bit, push on the WIDTH-th bit,
    // flag a fragment when the valid run ends with a partial word.
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        push         = 1'b0;
        frag_next    = 1'b0;
        push_word    = {shreg_reg[WIDTH-2:0], SerOut};
        case (state_reg)
            IDLE: begin
                if (SerOutValid) begin
                    shreg_next   = push_word;
                    bit_cnt_next = BW'(1);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (SerOutValid) begin
                    shreg_next = push_word;
                    if (bit_cnt_reg == BW'(WIDTH - 1)) begin
                        push         = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end else begin
                    frag_next    = (bit_cnt_reg != '0);
                    bit_cnt_next = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Assembler state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            frag_err    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            frag_err    <= frag_next;
        end
    end

    // FIFO control: a pop in the same cycle frees the slot, so a push into a
    // full FIFO is still accepted when the reader pops at the same time.
    always_comb begin
        full       = (count_reg == CW'(DEPTH));
        pop        = rd_en && (count_reg != '0);
        accept     = push && (!full || pop);
        drop       = push && full && !pop;
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO storage write port; the read side is combinational fall-through.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    // Pointers, occupancy, registered status flags and the sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            par_valid  <= 1'b0;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)    rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            par_valid <= (count_next != '0);
            fifo_full <= (count_next == CW'(DEPTH));
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head word is shown only while the FIFO holds data.
    always_comb begin
        par_data = par_valid ? mem[rd_ptr_reg] : '0;
    end

`ifdef SER_WORD_COLLECTOR_SSD_EN
    logic [6:0] ssd_reg;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0:    hex_glyph = 7'b0111111;
            4'h1:    hex_glyph = 7'b0000110;
            4'h2:    hex_glyph = 7'b1011011;
            4'h3:    hex_glyph = 7'b1001111;
            4'h4:    hex_glyph = 7'b1100110;
            4'h5:    hex_glyph = 7'b1101101;
            4'h6:    hex_glyph = 7'b1111101;
            4'h7:    hex_glyph = 7'b0000111;
            4'h8:    hex_glyph = 7'b1111111;
            default: hex_glyph = 7'b0000000;
        endcase
    endfunction

    // Display register follows the occupancy one cycle behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ssd_reg <= 7'b0111111;
        end else begin
            ssd_reg <= hex_glyph(4'(count_reg));
        end
    end

    assign SSD = ssd_reg;
`else
    assign SSD = 7'b0000000;
`endif

endmodule
